tone_pattern_capture: RTL and testbench

Receive-side counterpart to the 16-step speaker sequencer. It monitors a square-wave GPIO input against a programmed note half-period over 16 beat windows. Each step whose window carried that tone is marked as active, producing a 16-bit step pattern. Used for loopback self-test of the speaker path and for recording a pattern played from another board.

---
 rtl/tone_pattern_capture.sv | 149 ++++++++++++++
 tb/tb_tone_pattern_capture.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_pattern_capture.sv
// ============================================================================
//  tone_pattern_capture
//  Detects a programmed square-wave tone on gpio_in per beat window and
//  records a 16-step pattern (bit i = beat i carried the tone).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tone_pattern_capture #(
    parameter int NOTE_W    = 32,
    parameter int TOL_SHIFT = 3,
    parameter int MIN_HALF  = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              gpio_in,
    input  logic              beat_tick,
    input  logic              arm,
    input  logic [NOTE_W-1:0] note,
    output logic [15:0]       pattern,
    output logic [3:0]        current_beat,
    output logic              busy,
    output logic              done,
    output logic              tone_now
);

    localparam int                RUN_W   = $clog2(MIN_HALF + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MIN_HALF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAP  = 2'd2
    } state_t;

    state_t            state_q;
    logic              sync1_q, sync2_q, sync3_q, edge_q;
    logic [NOTE_W-1:0] hp_q, hp_d;
    logic [RUN_W-1:0]  run_q, run_d, run_nxt;
    logic              hit_q, hit_d;
    logic [15:0]       pattern_q;
    logic [3:0]        beat_q;
    logic              busy_q, done_q, tone_q;

    logic [NOTE_W:0]   w_interval, w_note_x, w_tol, w_limit, w_diff;
    logic              w_match, w_silent, w_hit_now, w_commit;

    // Interval arithmetic is one bit wider so note + tolerance never wraps.
    always_comb begin
        w_interval = {1'b0, hp_q} + {{NOTE_W{1'b0}}, 1'b1};
        w_note_x   = {1'b0, note};
        w_tol      = {1'b0, note >> TOL_SHIFT};
        w_limit    = w_note_x + w_tol;
        w_diff     = (w_interval >= w_note_x) ? (w_interval - w_note_x)
                                              : (w_note_x - w_interval);
        w_match    = (note != '0) && (w_diff <= w_tol);
        w_silent   = ({1'b0, hp_q} > w_limit);
    end

    always_comb begin
        hp_d    = hp_q;
        run_nxt = run_q;
        if (edge_q) begin
            hp_d = '0;
            if (w_match)
                run_nxt = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
            else
                run_nxt = '0;
        end else begin
            if (hp_q != '1)
                hp_d = hp_q + NOTE_W'(1);
            if (w_silent)
                run_nxt = '0;
        end
        // A tone completed by this cycle's edge counts toward a same-cycle commit.
        w_hit_now = hit_q | (run_nxt == RUN_MAX);
        w_commit  = beat_tick && (state_q != S_IDLE);
        run_d     = w_commit ? '0   : run_nxt;
        hit_d     = w_commit ? 1'b0 : w_hit_now;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            edge_q    <= 1'b0;
            hp_q      <= '0;
            run_q     <= '0;
            hit_q     <= 1'b0;
            state_q   <= S_IDLE;
            pattern_q <= '0;
            beat_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tone_q    <= 1'b0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q ^ sync3_q;
            hp_q    <= hp_d;
            run_q   <= run_d;
            hit_q   <= hit_d;
            tone_q  <= (run_d == RUN_MAX);
            done_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_q   <= S_WAIT;
                        pattern_q <= '0;
                        beat_q    <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (beat_tick)
                        state_q <= S_CAP;
                end
                S_CAP: begin
                    if (beat_tick) begin
                        pattern_q[beat_q] <= w_hit_now;
                        if (beat_q == 4'd15) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pattern      = pattern_q;
    assign current_beat = beat_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign tone_now     = tone_q;

endmodule

`default_nettype wire

// File: tb/tb_tone_pattern_capture.sv
// ============================================================================
//  tb_tone_pattern_capture
//  Directed self-checking bench for tone_pattern_capture.
//  Revision: 1.1
// ============================================================================
`default_nettype none

module tb_tone_pattern_capture;

    logic        clock;
    logic        resetn;
    logic        beat_tick;
    logic        arm;
    logic [31:0] note;
    wire         gpio_in;
    logic [15:0] pattern;
    logic [3:0]  current_beat;
    logic        busy, done, tone_now;

    logic        gen_gpio, man_gpio, gen_en;
    int          half_a, half_b;
    int          tests, fails;
    int          done_cnt, tone_cnt, done_before;

    assign gpio_in = gen_gpio ^ man_gpio;

    tone_pattern_capture #(.NOTE_W(32), .TOL_SHIFT(3), .MIN_HALF(4)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .gpio_in      (gpio_in),
        .beat_tick    (beat_tick),
        .arm          (arm),
        .note         (note),
        .pattern      (pattern),
        .current_beat (current_beat),
        .busy         (busy),
        .done         (done),
        .tone_now     (tone_now)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        int  cnt;
        logic use_b;
        gen_gpio = 1'b0;
        cnt      = 0;
        use_b    = 1'b0;
        forever begin
            @(negedge clock);
            if (gen_en) begin
                cnt++;
                if (cnt >= (use_b ? half_b : half_a)) begin
                    gen_gpio = ~gen_gpio;
                    cnt      = 0;
                    use_b    = ~use_b;
                end
            end else begin
                cnt   = 0;
                use_b = 1'b0;
            end
        end
    end

    initial begin
        done_cnt = 0;
        tone_cnt = 0;
        forever begin
            @(negedge clock);
            if (done)     done_cnt++;
            if (tone_now) tone_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic tick_pulse();
        beat_tick = 1'b1;
        cyc(1);
        beat_tick = 1'b0;
    endtask

    task automatic arm_and_align();
        arm = 1'b1;
        cyc(1);
        arm = 1'b0;
        cyc(20);
        tick_pulse();
    endtask

    task automatic run_beats(input logic [15:0] tones, input int tone_len, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            gen_en = tones[b];
            cyc(tones[b] ? tone_len : 20);
            tick_pulse();
            gen_en = 1'b0;
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        resetn    = 1'b0;
        beat_tick = 1'b0;
        arm       = 1'b0;
        note      = 32'd3;
        man_gpio  = 1'b0;
        gen_en    = 1'b1;
        half_a    = 3;
        half_b    = 3;

        cyc(30);
        check("rst_pattern", pattern, 16'h0000);
        check("rst_beat", current_beat, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tone", tone_now, 1'b0);
        gen_en = 1'b0;
        cyc(2);
        resetn = 1'b1;
        cyc(10);
        check("post_rst_busy", busy, 1'b0);

        note   = 32'd100;
        half_a = 100;
        half_b = 100;
        done_before = done_cnt;
        arm_and_align();
        check("lb_busy", busy, 1'b1);
        run_beats(16'h8025, 800, 16);
        check("lb_done_edge", done, 1'b1);
        check("lb_busy_fall", busy, 1'b0);
        check("lb_pattern", pattern, 16'h8025);
        check("lb_beat", current_beat, 4'd15);
        cyc(1);
        check("lb_done_low", done, 1'b0);
        cyc(30);
        check("lb_done_count", done_cnt - done_before, 1);
        check("lb_hold", pattern, 16'h8025);

        note   = 32'd80;
        half_a = 90;
        half_b = 90;
        arm_and_align();
        run_beats(16'h0001, 600, 16);
        check("tol_90", pattern, 16'h0001);
        half_a = 91;
        half_b = 91;
        arm_and_align();
        run_beats(16'h0001, 600, 16);
        check("tol_91", pattern, 16'h0000);
        half_a = 80;
        half_b = 200;
        arm_and_align();
        run_beats(16'h0001, 1500, 16);
        check("tol_alt", pattern, 16'h0000);

        half_a = 80;
        half_b = 80;
        arm_and_align();
        cyc(200);
        for (int i = 0; i < 5; i++) begin
            man_gpio = ~man_gpio;
            if (i < 4) cyc(80);
        end
        cyc(3);
        tick_pulse();
        check("sim_bit0", pattern[0], 1'b1);
        check("sim_tone_cleared", tone_now, 1'b0);
        check("sim_beat1", current_beat, 4'd1);
        cyc(76);
        for (int i = 0; i < 3; i++) begin
            man_gpio = ~man_gpio;
            if (i < 2) cyc(80);
        end
        cyc(10);
        check("sim_run_restart", tone_now, 1'b0);
        tick_pulse();
        run_beats(16'h0000, 20, 14);
        check("sim_pattern", pattern, 16'h0001);
        check("sim_done", done, 1'b1);

        note     = 32'd0;
        half_a   = 5;
        half_b   = 5;
        gen_en   = 1'b1;
        cyc(5);
        tone_cnt = 0;
        arm       = 1'b1;
        beat_tick = 1'b1;
        cyc(1);
        arm       = 1'b0;
        beat_tick = 1'b0;
        check("armtick_busy", busy, 1'b1);
        cyc(20);
        tick_pulse();
        for (int b = 0; b < 15; b++) begin
            cyc(30);
            tick_pulse();
        end
        check("armtick_still_busy", busy, 1'b1);
        check("armtick_no_done", done, 1'b0);
        cyc(30);
        tick_pulse();
        check("armtick_done", done, 1'b1);
        check("note0_pattern", pattern, 16'h0000);
        gen_en = 1'b0;
        cyc(5);
        check("note0_tone_never", tone_cnt, 0);

        note   = 32'd100;
        half_a = 100;
        half_b = 100;
        arm_and_align();
        run_beats(16'h0008, 800, 8);
        check("mid_pattern", pattern, 16'h0008);
        check("mid_beat", current_beat, 4'd8);
        done_before = done_cnt;
        resetn = 1'b0;
        #2;
        check("mid_rst_pattern", pattern, 16'h0000);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_beat", current_beat, 4'd0);
        cyc(2);
        resetn = 1'b1;
        cyc(10);
        check("mid_rst_no_done", done_cnt, done_before);
        arm_and_align();
        run_beats(16'h4002, 800, 16);
        check("rearm_pattern", pattern, 16'h4002);
        check("rearm_done", done, 1'b1);
        check("rearm_beat", current_beat, 4'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
